// File: rtl/cm0_ahb_sram_slv_pkg.sv
// Shared encodings and helpers for the AHB-Lite SRAM responder.
package cm0_ahb_sram_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Address-phase attributes carried into the data phase
  typedef struct packed {
    logic       write;
    logic [3:0] mask;
  } aphase_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 4'(4'b0001 << a);
      HSIZE_HALF: return 4'(4'b0011 << a);
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic size_illegal(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 1'b0;
      HSIZE_HALF: return a[0];
      HSIZE_WORD: return (a != 2'b00);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/cm0_sram_array.sv
// Word-organised storage: synchronous byte-enabled write, asynchronous read.
module cm0_sram_array #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata_c
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/cm0_ahb_sram_slv.sv
// AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR.
module cm0_ahb_sram_slv
  import cm0_ahb_sram_slv_pkg::*;
#(
  parameter int unsigned AW   = 10,
  parameter int unsigned WAIT = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned CW = 3;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] word_q, word_d;
  aphase_t       aph_q, aph_d;
  logic          hreadyout_q, hreadyout_d;
  logic          hresp_q, hresp_d;
  logic          accept_c;
  logic          illegal_c;
  logic          we_c;
  logic [31:0]   rdata_c;
  logic          unused_haddr;

  assign unused_haddr = ^HADDR[31:AW+2];

  assign accept_c  = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign illegal_c = size_illegal(HSIZE, HADDR[1:0]);

  // Next state; IDLE, DATA and ERR2 all sample a new address phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    aph_d   = aph_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = CW'(cnt_q - 1'b1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          word_d     = HADDR[AW+1:2];
          aph_d.write = HWRITE;
          aph_d.mask  = lane_mask(HSIZE, HADDR[1:0]);
          if (illegal_c) begin
            state_d = ST_ERR1;
          end else if (WAIT != 0) begin
            state_d = ST_WAIT;
            cnt_d   = CW'(WAIT - 1);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
    hreadyout_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
    hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      aph_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      aph_q       <= aph_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Write commits on the edge that ends the DATA cycle; reset forces IDLE so a pending write is dropped
  assign we_c = (state_q == ST_DATA) && aph_q.write;

  cm0_sram_array #(.AW(AW)) u_array (
    .clk     (HCLK),
    .we      (we_c),
    .waddr   (word_q),
    .wbe     (aph_q.mask),
    .wdata   (HWDATA),
    .raddr   (word_q),
    .rdata_c (rdata_c)
  );

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = (state_q == ST_DATA && !aph_q.write) ? rdata_c : 32'h0;

endmodule
